data_memory_ws: RTL
===================

Name: data_memory_ws

Overview:
- Parametrised word-addressed data memory with programmable wait states and a valid/ready request handshake.
- Single-beat response pulse; per-byte write enables; alignment and range checking.
- Sits behind the memory controller in the MEM stage; the controller stalls the pipeline while ReqReady is low or a response is pending.

Parameters:
WIDTH, 32, data word width in bits; multiple of 8, ≥16.
DEPTH, 64, number of WIDTH-bit words.
LATENCY, 2, wait-state cycles between acceptance and response, 0..15.
BE_W, WIDTH/8, ByteEnable width (derived; do not override).

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
ReqValid  in  1  request present.
ReqReady  out  1  block can accept a request this cycle.
Address  in  32  byte address.
WriteData  in  WIDTH  store data.
WriteEnable  in  1  1 = store, 0 = load.
ByteEnable  in  BE_W  per-byte store mask; ByteEnable[i] covers bits 8i+7:8i.
RespValid  out  1  one-cycle response pulse.
RespError  out  1  response is an error; valid only with RespValid.
ReadData  out  WIDTH  load result; valid with RespValid.

Behaviour:
- Reset (async assert, sync deassert in the enclosing design): state=IDLE, ReqReady=1, RespValid=0, RespError=0, ReadData=0, wait counter=0. RAM contents are not reset; they initialise to zero at time 0 only.
- Word index = Address >> log2(BE_W).
- Misaligned: Address[log2(BE_W)-1:0] != 0.
- Out of range: word index ≥ DEPTH.
- Either misaligned or out of range is an error.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ReqReady=1.
  - Acceptance happens on a rising edge where ReqValid=1; it captures Address, WriteData, WriteEnable, ByteEnable and the error flag.
  - After acceptance: go to WAIT with counter=LATENCY if LATENCY>0, else go to RESP.
- WAIT:
  - ReqReady=0.
  - Counter decrements each edge; on the edge where counter==1, go to RESP.
- Commit edge (the edge entering RESP):
  - Store without error: RAM[index] byte i ← WriteData byte i where ByteEnable[i]=1, else unchanged.
  - Load without error: ReadData ← RAM[index].
  - Store, or any error: ReadData ← 0.
  - RespError ← error flag.
- RESP:
  - RespValid=1 for exactly one cycle; ReqReady=0.
  - Next edge goes to IDLE and clears RespValid and RespError.
  - ReadData holds its value until the next commit.
- Latency: RespValid is high in the (LATENCY+1)th cycle after the acceptance cycle. One transaction every LATENCY+2 cycles at most.
- Error requests consume the same latency, never write RAM, and return ReadData=0 with RespError=1.
- ByteEnable=0 on a store: completes normally with no RAM change and RespError=0.
- ByteEnable is ignored for loads; the full word is always returned. Byte/half extraction belongs to the controller.
- Inputs may change freely after acceptance; only captured values are used.
- ReqValid in WAIT/RESP is ignored and is not queued.
- Reset mid-transaction (WAIT or RESP): transaction aborted, pending store not committed, outputs return to reset values immediately.
- No response back-pressure: the consumer must sample RespValid in its cycle.

Test Plan:
- LATENCY=2, store 0xDEADBEEF to 0x10 with BE=4'b1111, then load 0x10 → store RespValid in the 3rd cycle after acceptance with RespError=0; load ReadData=0xDEADBEEF; ReqReady low for 3 cycles per transaction.
- Store 0x11223344 with BE=4'b1111, then 0xAABBCCDD with BE=4'b0101 to 0x20, then load 0x20 → ReadData=0x11BB33DD.
- Load 0x22 (misaligned) and load 0x100 (word 64 ≥ DEPTH) → RespError=1, ReadData=0. A store to 0x101 leaves word 0 (previously 0x5) unchanged on reload.
- LATENCY=0 build: store then load at 0x4 → RespValid the cycle after each acceptance; ReqValid held high continuously is accepted every 2nd cycle.
- Accept a store of 0xCAFEF00D to 0x8, pulse RST_N low during WAIT → RespValid never asserts, ReqReady=1 immediately; a later load of 0x8 returns the old value 0x0.
- Assert ReqValid with a different address during WAIT → ignored; only the original transaction responds, and the second request is accepted only once back in IDLE.

Source files
------------

// File: rtl/data_memory_ws.sv
// Word-addressed data memory with a fixed number of wait states behind a valid/ready request port.
// Each accepted request yields one single-cycle response; bad addresses return an error and never touch the RAM.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a request; acceptance captures the request
// ST_WAIT | counting down wait states; the commit happens on the edge leaving it
// ST_RESP | RespValid pulse; ReadData/RespError reflect the committed access
module data_memory_ws #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2,
   parameter int BE_W    = WIDTH / 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             ReqValid,
   output logic             ReqReady,
   input  logic [31:0]      Address,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             WriteEnable,
   input  logic [BE_W-1:0]  ByteEnable,
   output logic             RespValid,
   output logic             RespError,
   output logic [WIDTH-1:0] ReadData
);

   localparam int OFFS  = $clog2(BE_W);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             we_q, we_d;
   logic [BE_W-1:0]  be_q, be_d;
   logic             err_q, err_d;
   logic             resp_err_q, resp_err_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;

   // Contents are never reset; they start at zero at time 0 only.
   logic [WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

   logic [31:0]      word_full;
   logic [IDX_W-1:0] req_idx;
   logic             req_err;

   assign word_full = Address >> OFFS;
   assign req_idx   = word_full[IDX_W-1:0];
   assign req_err   = (Address[OFFS-1:0] != '0) || (word_full >= 32'(DEPTH));

   logic             commit;
   logic             mem_we;
   logic [IDX_W-1:0] c_idx;
   logic [WIDTH-1:0] c_wdata;
   logic             c_we;
   logic [BE_W-1:0]  c_be;
   logic             c_err;
   logic [WIDTH-1:0] old_word;
   logic [WIDTH-1:0] merged;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      be_d       = be_q;
      err_d      = err_q;
      resp_err_d = resp_err_q;
      rdata_d    = rdata_q;
      commit     = 1'b0;
      c_idx      = idx_q;
      c_wdata    = wdata_q;
      c_we       = we_q;
      c_be       = be_q;
      c_err      = err_q;

      case (state_q)
         ST_IDLE: begin
            if (ReqValid) begin
               idx_d   = req_idx;
               wdata_d = WriteData;
               we_d    = WriteEnable;
               be_d    = ByteEnable;
               err_d   = req_err;
               // With no wait states the acceptance edge is also the commit edge.
               c_idx   = req_idx;
               c_wdata = WriteData;
               c_we    = WriteEnable;
               c_be    = ByteEnable;
               c_err   = req_err;
               if (LATENCY > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(LATENCY);
               end else begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end
         end
         ST_RESP: begin
            state_d    = ST_IDLE;
            resp_err_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      old_word = mem_q[c_idx];
      merged   = old_word;
      for (int i = 0; i < BE_W; i++) begin
         if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];
      end

      if (commit) begin
         resp_err_d = c_err;
         rdata_d    = (!c_we && !c_err) ? old_word : '0;
      end
      mem_we = commit && c_we && !c_err;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         be_q       <= '0;
         err_q      <= 1'b0;
         resp_err_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         be_q       <= be_d;
         err_q      <= err_d;
         resp_err_q <= resp_err_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[c_idx] <= merged;
   end

   assign ReqReady  = (state_q == ST_IDLE);
   assign RespValid = (state_q == ST_RESP);
   assign RespError = resp_err_q;
   assign ReadData  = rdata_q;

endmodule
